// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 opcodes, e_control field positions and decode helpers
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam int ECTL_ALU_HI    = 5;
    localparam int ECTL_ALU_LO    = 4;
    localparam int ECTL_PCSEL1_HI = 3;
    localparam int ECTL_PCSEL1_LO = 2;
    localparam int ECTL_PCSEL2    = 1;
    localparam int ECTL_OP2SEL    = 0;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_ZERO = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_OFF11 = 2'b00,
        PC_OFF9  = 2'b01,
        PC_OFF6  = 2'b10,
        PC_OFF0  = 2'b11
    } pc_off_e;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic writes_dr(input logic [3:0] op);
        return is_alu_op(op) || (op == OP_LD) || (op == OP_LDR) ||
               (op == OP_LDI) || (op == OP_LEA);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU and PC/address adder for the execute stage
module exec_alu
    import lc3_pkg::*;
(
    input  logic [1:0]  alu_control_i,
    input  logic [1:0]  pcselect1_i,
    input  logic        pcselect2_i,
    input  logic [15:0] op1_i,
    input  logic [15:0] op2_i,
    input  logic [15:0] npc_i,
    input  logic [10:0] ir_off_i,
    output logic [15:0] alu_result_o,
    output logic [15:0] pc_result_o
);

    logic [15:0] base;
    logic [15:0] offset;

    always_comb begin
        alu_result_o = 16'h0000;
        case (alu_op_e'(alu_control_i))
            ALU_ADD:  alu_result_o = op1_i + op2_i;
            ALU_AND:  alu_result_o = op1_i & op2_i;
            ALU_NOT:  alu_result_o = ~op1_i;
            ALU_ZERO: alu_result_o = 16'h0000;
            default:  alu_result_o = 16'h0000;
        endcase
    end

    always_comb begin
        offset = 16'h0000;
        case (pc_off_e'(pcselect1_i))
            PC_OFF11: offset = {{5{ir_off_i[10]}}, ir_off_i[10:0]};
            PC_OFF9:  offset = {{7{ir_off_i[8]}}, ir_off_i[8:0]};
            PC_OFF6:  offset = {{10{ir_off_i[5]}}, ir_off_i[5:0]};
            PC_OFF0:  offset = 16'h0000;
            default:  offset = 16'h0000;
        endcase
    end

    assign base        = pcselect2_i ? npc_i : op1_i;
    assign pc_result_o = base + offset;

endmodule

// File: rtl/execute.sv
// rtl/execute.sv - LC-3 execute stage; define EXEC_BYPASS_EN to enable operand forwarding
module execute
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_execute,
    input  logic [5:0]  e_control,
    input  logic [15:0] ir,
    input  logic [15:0] npc_in,
    input  logic [1:0]  w_control_in,
    input  logic        mem_control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] mem_bypass_val,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [15:0] M_Data,
    output logic [15:0] IR_Exec,
    output logic [2:0]  dr,
    output logic [2:0]  NZP,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out
);

    logic [3:0]  opcode;
    logic [15:0] op1;
    logic [15:0] vsr2_eff;
    logic [15:0] op2;
    logic [15:0] alu_result;
    logic [15:0] pc_result;

    logic [15:0] aluout_q, aluout_d;
    logic [15:0] pcout_q,  pcout_d;
    logic [15:0] m_data_q, m_data_d;
    logic [15:0] ir_exec_q, ir_exec_d;
    logic [2:0]  dr_q, dr_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [1:0]  w_control_q, w_control_d;
    logic        mem_control_q, mem_control_d;

    assign opcode = ir[15:12];
    assign sr1    = ir[8:6];
    assign sr2    = is_store(opcode) ? ir[11:9] : ir[2:0];

`ifdef EXEC_BYPASS_EN
    // ALU forwarding is the younger result, so it wins over the memory path
    assign op1      = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? mem_bypass_val : VSR1);
    assign vsr2_eff = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? mem_bypass_val : VSR2);
`else
    logic unused_bypass;
    assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
                             mem_bypass_val};
    assign op1      = VSR1;
    assign vsr2_eff = VSR2;
`endif

    assign op2 = e_control[ECTL_OP2SEL] ? vsr2_eff : {{11{ir[4]}}, ir[4:0]};

    exec_alu u_exec_alu (
        .alu_control_i (e_control[ECTL_ALU_HI:ECTL_ALU_LO]),
        .pcselect1_i   (e_control[ECTL_PCSEL1_HI:ECTL_PCSEL1_LO]),
        .pcselect2_i   (e_control[ECTL_PCSEL2]),
        .op1_i         (op1),
        .op2_i         (op2),
        .npc_i         (npc_in),
        .ir_off_i      (ir[10:0]),
        .alu_result_o  (alu_result),
        .pc_result_o   (pc_result)
    );

    always_comb begin
        aluout_d      = is_alu_op(opcode) ? alu_result : aluout_q;
        pcout_d       = pc_result;
        m_data_d      = vsr2_eff;
        ir_exec_d     = ir;
        dr_d          = writes_dr(opcode) ? ir[11:9] : 3'b000;
        nzp_d         = 3'b000;
        w_control_d   = w_control_in;
        mem_control_d = mem_control_in;
        if (opcode == OP_BR) begin
            nzp_d = ir[11:9];
        end else if (opcode == OP_JMP) begin
            nzp_d = 3'b111;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluout_q      <= 16'h0000;
            pcout_q       <= 16'h0000;
            m_data_q      <= 16'h0000;
            ir_exec_q     <= 16'h0000;
            dr_q          <= 3'b000;
            nzp_q         <= 3'b000;
            w_control_q   <= 2'b00;
            mem_control_q <= 1'b0;
        end else if (enable_execute) begin
            aluout_q      <= aluout_d;
            pcout_q       <= pcout_d;
            m_data_q      <= m_data_d;
            ir_exec_q     <= ir_exec_d;
            dr_q          <= dr_d;
            nzp_q         <= nzp_d;
            w_control_q   <= w_control_d;
            mem_control_q <= mem_control_d;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign M_Data          = m_data_q;
    assign IR_Exec         = ir_exec_q;
    assign dr              = dr_q;
    assign NZP             = nzp_q;
    assign W_Control_out   = w_control_q;
    assign Mem_Control_out = mem_control_q;

endmodule
